// File: rtl/convert_arb.sv
// Round-robin N_REQ-to-1 arbiter feeding a fixed-point format converter and a one-entry output register.
// Optional macro CONVERT_ARB_ROUND_EN: round half up before truncation instead of truncating only.
module convert_arb #(
  parameter int N_REQ      = 4,
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*N_BITS_IN-1:0]   req_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_BITS_OUT-1:0]        out_data,
  output logic [ID_W-1:0]              out_id,
  output logic [15:0]                  sat_count
);

  // Right shift drops input LSBs below the output LSB; left shift zero-pads missing LSBs.
  localparam int SHR = (BIN_PT_IN > BIN_PT_OUT) ? BIN_PT_IN - BIN_PT_OUT : 0;
  localparam int SHL = (BIN_PT_OUT > BIN_PT_IN) ? BIN_PT_OUT - BIN_PT_IN : 0;
  localparam int WW  = N_BITS_IN + SHL + SHR + N_BITS_OUT + 2;

  localparam logic signed [WW-1:0] OUT_MAX = signed'((WW'(1) << (N_BITS_OUT - 1)) - WW'(1));
  localparam logic signed [WW-1:0] OUT_MIN = ~OUT_MAX;

`ifdef CONVERT_ARB_ROUND_EN
  localparam int RND_SH = (SHR > 0) ? SHR - 1 : 0;
  localparam logic signed [WW-1:0] ROUND_HALF = (SHR > 0) ? signed'(WW'(1) << RND_SH) : '0;
`endif

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_found;
  logic                    accept;
  logic [N_BITS_IN-1:0]    sel_data;
  logic signed [WW-1:0]    ext;
  logic signed [WW-1:0]    shifted;
  logic [N_BITS_OUT-1:0]   conv_data;
  logic                    conv_sat;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_found && req_valid[(int'(last_grant) + i) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(last_grant) + i) % N_REQ);
      end
    end
  end

  assign accept    = !rst && grant_found && ((state_q == EMPTY) || out_ready);
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign sel_data  = req_data[int'(grant_idx) * N_BITS_IN +: N_BITS_IN];
  assign out_valid = (state_q == FULL);

  // Work in a wide signed domain so shifts and the rounding add never overflow before the range check.
  always_comb begin
    ext = {{(WW - N_BITS_IN){sel_data[N_BITS_IN-1]}}, sel_data};
`ifdef CONVERT_ARB_ROUND_EN
    ext = ext + ROUND_HALF;
`endif
    shifted  = (ext >>> SHR) <<< SHL;
    conv_sat = 1'b0;
    if (shifted > OUT_MAX) begin
      conv_data = OUT_MAX[N_BITS_OUT-1:0];
      conv_sat  = 1'b1;
    end else if (shifted < OUT_MIN) begin
      conv_data = OUT_MIN[N_BITS_OUT-1:0];
      conv_sat  = 1'b1;
    end else begin
      conv_data = shifted[N_BITS_OUT-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= EMPTY;
      // NOTE: the result registers are reset as well, so out_data/out_id read 0 rather than stale data.
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      sat_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data   <= conv_data;
        out_id     <= grant_idx;
        last_grant <= grant_idx;
        if (conv_sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_convert_arb.sv
// Self-checking bench for convert_arb: directed scenarios plus randomized traffic against a
// fixed-point reference model built from real-valued floor/round arithmetic.
module tb_convert_arb;

`ifdef CONVERT_ARB_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam logic [3:0] EXP_5A = ROUND ? 4'h6 : 4'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic [15:0] sat_count;

  // Second/third instances share stimulus: wide output (12.8) and a narrow, saturating one (4.5).
  logic [3:0]  x_valid;
  logic [31:0] x_data;
  logic        x_out_ready;
  logic [3:0]  w_req_ready, s_req_ready;
  logic        w_out_valid, s_out_valid;
  logic [11:0] w_out_data;
  logic [3:0]  s_out_data;
  logic [1:0]  w_out_id, s_out_id;
  logic [15:0] w_sat, s_sat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  convert_arb u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .sat_count(sat_count)
  );

  convert_arb #(.N_BITS_OUT(12), .BIN_PT_OUT(8)) u_wide (
    .clk(clk), .rst(rst), .req_valid(x_valid), .req_ready(w_req_ready), .req_data(x_data),
    .out_valid(w_out_valid), .out_ready(x_out_ready), .out_data(w_out_data), .out_id(w_out_id),
    .sat_count(w_sat)
  );

  convert_arb #(.N_BITS_OUT(4), .BIN_PT_OUT(5)) u_sat (
    .clk(clk), .rst(rst), .req_valid(x_valid), .req_ready(s_req_ready), .req_data(x_data),
    .out_valid(s_out_valid), .out_ready(x_out_ready), .out_data(s_out_data), .out_id(s_out_id),
    .sat_count(s_sat)
  );

  // ---------------- reference model ----------------
  bit         m_full;
  logic [3:0] m_data;
  logic [1:0] m_id;
  int         m_last;
  int         m_sat;
  logic [3:0] obs_ready, exp_ready;
  int         acc;

  function automatic longint fdiv(longint a, longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // value = x / 2^7; result = floor(value * 2^bpo [+ 1/2]) clamped to nbo-bit signed range.
  function automatic longint conv(logic [7:0] b, int nbo, int bpo, output bit sat);
    longint x  = longint'($signed(b));
    longint d  = longint'(1) <<< 7;
    longint e  = longint'(1) <<< bpo;
    longint hi = (longint'(1) <<< (nbo - 1)) - 1;
    longint lo = -hi - 1;
    longint q;
    if (ROUND) q = fdiv(2 * x * e + d, 2 * d);
    else       q = fdiv(x * e, d);
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    return q;
  endfunction

  function automatic int model_grant(logic [3:0] v);
    for (int i = 1; i <= 4; i++) begin
      if (v[(m_last + i) % 4]) return (m_last + i) % 4;
    end
    return -1;
  endfunction

  // One clock: capture req_ready mid-cycle, predict the grant, then advance the model past the edge.
  task automatic tick();
    int     g;
    bit     sat;
    longint q;
    @(negedge clk);
    obs_ready = req_ready;
    g = model_grant(req_valid);
    exp_ready = (!rst && g >= 0 && (!m_full || out_ready)) ? (4'b0001 << g) : 4'b0000;
    @(posedge clk);
    #1;
    acc = -1;
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_id = '0; m_last = 3; m_sat = 0;
    end else if (exp_ready != 4'b0000) begin
      q = conv(req_data[g*8 +: 8], 4, 3, sat);
      m_data = q[3:0];
      m_id   = 2'(g);
      m_last = g;
      m_full = 1'b1;
      if (sat && m_sat < 16'hFFFF) m_sat++;
      acc = g;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = $urandom; out_ready = 1'b1;
    x_valid = 4'h0; x_data = '0; x_out_ready = 1'b1;
    tick();
    n_cmp++; if (obs_ready !== 4'h0) begin n_err++; $display("FAIL rst_ready: got %h want 0", obs_ready); end
    tick();
    rst = 1'b0; req_valid = 4'h0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL rst_out_id: got %0d want 0", out_id); end
    n_cmp++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL rst_sat_count: got %0d want 0", sat_count); end
  endtask

  task automatic test_basic();
    req_valid = 4'b0001; req_data = 32'h0000_005A; out_ready = 1'b1;
    tick();
    req_valid = 4'h0;
    n_cmp++; if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL basic_ready: got %h want 1", obs_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== EXP_5A) begin n_err++; $display("FAIL basic_data: got %h want %h", out_data, EXP_5A); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL basic_id: got %0d want 0", out_id); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    req_valid = 4'b0001; req_data = 32'h0000_007F; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 4'h7) begin n_err++; $display("FAIL sat_7f_data: got %h want 7", out_data); end
    n_cmp++; if (sat_count !== 16'(ROUND ? 1 : 0)) begin n_err++; $display("FAIL sat_7f_count: got %0d want %0d", sat_count, ROUND ? 1 : 0); end
    req_data = 32'h0000_0080;
    tick();
    req_valid = 4'h0;
    n_cmp++; if (out_data !== 4'h8) begin n_err++; $display("FAIL sat_80_data: got %h want 8", out_data); end
    n_cmp++; if (sat_count !== 16'(m_sat)) begin n_err++; $display("FAIL sat_80_count: got %0d want %0d", sat_count, m_sat); end
    tick();
  endtask

  task automatic test_round_robin();
    int start;
    req_valid = 4'hF; req_data = $urandom; out_ready = 1'b1;
    start = (m_last + 1) % 4;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++; if (obs_ready !== 4'(1 << ((start + c) % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %h want %h", c, obs_ready, 4'(1 << ((start + c) % 4))); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", c, out_valid); end
      n_cmp++; if (out_id !== 2'((start + c) % 4)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", c, out_id, (start + c) % 4); end
      n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", c, out_data, m_data); end
      if (acc >= 0) req_data[acc*8 +: 8] = 8'($urandom);
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] held_d;
    logic [1:0] held_id;
    req_valid = 4'hF; req_data = $urandom; out_ready = 1'b1;
    tick();
    held_d = m_data; held_id = m_id;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (obs_ready !== 4'h0) begin n_err++; $display("FAIL bp_ready[%0d]: got %h want 0", c, obs_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      n_cmp++; if (out_data !== held_d) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", c, out_data, held_d); end
      n_cmp++; if (out_id !== held_id) begin n_err++; $display("FAIL bp_id[%0d]: got %0d want %0d", c, out_id, held_id); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (obs_ready !== 4'(1 << ((held_id + 1) % 4))) begin n_err++; $display("FAIL bp_release_ready: got %h want %h", obs_ready, 4'(1 << ((held_id + 1) % 4))); end
    n_cmp++; if (out_id !== 2'((held_id + 1) % 4)) begin n_err++; $display("FAIL bp_release_id: got %0d want %0d", out_id, (held_id + 1) % 4); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010; req_data = 32'h0000_7F00; out_ready = 1'b1;
    tick();
    req_valid = 4'h0; out_ready = 1'b0;
    tick();
    rst = 1'b1; req_valid = 4'hF;
    tick();
    n_cmp++; if (obs_ready !== 4'h0) begin n_err++; $display("FAIL rm_ready: got %h want 0", obs_ready); end
    rst = 1'b0; req_valid = 4'h0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    n_cmp++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL rm_sat: got %0d want 0", sat_count); end
    req_valid = 4'hF; out_ready = 1'b1;
    tick();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL rm_first_grant: got %h want 1", obs_ready); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL rm_first_id: got %0d want 0", out_id); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] pend_v = 4'h0;
    logic [7:0] pend_d [4];
    bit         idle;
    for (int i = 0; i < 4; i++) pend_d[i] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      idle = (c >= 150 && c < 170);
      for (int i = 0; i < 4; i++) begin
        if (!pend_v[i] && !idle && $urandom_range(0, 1) == 1) begin
          pend_v[i] = 1'b1;
          case ($urandom_range(0, 3))
            0: pend_d[i] = 8'h7F;
            1: pend_d[i] = 8'h80;
            default: pend_d[i] = 8'($urandom);
          endcase
        end
        req_data[i*8 +: 8] = pend_d[i];
      end
      req_valid = pend_v;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %h want %h", c, obs_ready, exp_ready); end
      n_cmp++; if (out_valid !== m_full) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_full); end
      if (m_full) begin
        n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, out_data, m_data); end
        n_cmp++; if (out_id !== m_id) begin n_err++; $display("FAIL rnd_id[%0d]: got %0d want %0d", c, out_id, m_id); end
      end
      n_cmp++; if (sat_count !== 16'(m_sat)) begin n_err++; $display("FAIL rnd_sat[%0d]: got %0d want %0d", c, sat_count, m_sat); end
      if (acc >= 0) pend_v[acc] = 1'b0;
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_alignments();
    logic [7:0] v;
    longint     qw, qs;
    bit         sw, ss;
    int         xs_sat = 0;
    x_valid = 4'b0001; x_out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      v = (c == 0) ? 8'h80 : (c == 1) ? 8'h40 : 8'($urandom);
      x_data = {24'h0, v};
      @(posedge clk);
      #1;
      qw = conv(v, 12, 8, sw);
      qs = conv(v, 4, 5, ss);
      if (ss) xs_sat++;
      if (c == 0) begin
        n_cmp++; if (w_out_data !== 12'hF00) begin n_err++; $display("FAIL wide_m1: got %h want f00", w_out_data); end
      end
      if (c == 1) begin
        n_cmp++; if (w_out_data !== 12'h080) begin n_err++; $display("FAIL wide_half: got %h want 080", w_out_data); end
      end
      n_cmp++; if (w_out_valid !== 1'b1) begin n_err++; $display("FAIL wide_valid[%0d]: got %b want 1", c, w_out_valid); end
      n_cmp++; if (w_out_data !== qw[11:0]) begin n_err++; $display("FAIL wide_data[%0d] in=%h: got %h want %h", c, v, w_out_data, qw[11:0]); end
      n_cmp++; if (s_out_data !== qs[3:0]) begin n_err++; $display("FAIL narrow_data[%0d] in=%h: got %h want %h", c, v, s_out_data, qs[3:0]); end
      n_cmp++; if (s_sat !== 16'(xs_sat)) begin n_err++; $display("FAIL narrow_sat[%0d]: got %0d want %0d", c, s_sat, xs_sat); end
    end
    x_valid = 4'h0;
  endtask

  initial begin
    m_full = 1'b0; m_data = '0; m_id = '0; m_last = 3; m_sat = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_alignments();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
